// File: rtl/fetch_sequencer.sv
// fetch_sequencer: YuCore PC owner and instruction fetch sequencer.
// Handles variable-latency imem, redirects, traps, halt and bus timeout.
module fetch_sequencer #(
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_VECTOR   = '0,
    parameter int unsigned             TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  trap_valid,
    input  logic [DATA_WIDTH-1:0] trap_vector,
    input  logic                  halt_req,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  fetch_fault,
    output logic                  halted
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  fault_q, fault_d;
    logic                  drop_q, drop_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] tv_al;
    logic                  tv_mis;
    logic [DATA_WIDTH-1:0] nxt_pc;
    logic                  tmo;

    assign tv_al  = {trap_vector[DATA_WIDTH-1:2], 2'b00};
    assign tv_mis = |trap_vector[1:0];
    assign nxt_pc = redirect_valid ? redirect_target
                                   : pc_q + DATA_WIDTH'(4);
    assign tmo    = (cnt_q == CNT_LAST);

    // Next-state, PC update, drain flag and timeout counter.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        drop_d     = drop_q;
        fault_d    = 1'b0;
        cnt_d      = '0;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (trap_valid) begin
                    pc_d    = tv_al;
                    fault_d = tv_mis;
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end else if (tmo) begin
                    fault_d = 1'b1;
                    pc_d    = tv_al;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (trap_valid) begin
                    pc_d    = tv_al;
                    fault_d = tv_mis;
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = S_HOLD;
                    end
                end else if (tmo) begin
                    fault_d = 1'b1;
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        pc_d   = tv_al;
                        drop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (trap_valid) begin
                    pc_d    = tv_al;
                    fault_d = tv_mis;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    if (|nxt_pc[1:0]) begin
                        fault_d = 1'b1;
                        pc_d    = tv_al;
                        state_d = S_REQ;
                    end else begin
                        pc_d    = nxt_pc;
                        state_d = halt_req ? S_HALT : S_REQ;
                    end
                end
            end
            S_HALT: begin
                if (trap_valid) begin
                    pc_d    = tv_al;
                    fault_d = tv_mis;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign fetch_fault = fault_q;
    assign halted      = (state_q == S_HALT);

endmodule
